// File: rtl/pito_pkg.sv
// Shared definitions for the Pito data-memory router and its neighbours.
//
// Contents:
//   PITO_MMIO_TXDATA - MMIO offset of the UART transmit data register
//   PITO_MMIO_STATUS - MMIO offset of the TX FIFO status register
//   pito_tx_state_e  - encoding of the UART drain state machine
package pito_pkg;

  localparam logic [7:0] PITO_MMIO_TXDATA = 8'h00;
  localparam logic [7:0] PITO_MMIO_STATUS = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } pito_tx_state_e;

endpackage

// File: rtl/pito_dmem_router_if.sv
// Bundle of every bus signal around the data-memory router.
//
// Groups:
//   core_* - request/grant/rvalid port from rv32_core's dmem interface
//   mem_*  - local port of the shared data SRAM (1-cycle read latency)
//   uart_* - write strobe/data towards pito_uart plus its busy flag
//   tx_overflow - sticky flag raised by dropped MMIO writes
//
// Modports:
//   slave  - the router itself
//   master - the surroundings (core, SRAM, UART), e.g. a testbench
interface pito_dmem_router_if #(
  parameter int DATA_WIDTH = 32
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  core_req;
  logic                  core_we;
  logic [DATA_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [BE_WIDTH-1:0]   core_be;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  uart_wr;
  logic [7:0]            uart_data;
  logic                  uart_busy;

  logic                  tx_overflow;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_be,
    output core_gnt, core_rvalid, core_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata,
    output uart_wr, uart_data,
    input  uart_busy,
    output tx_overflow
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_be,
    input  core_gnt, core_rvalid, core_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata,
    input  uart_wr, uart_data,
    output uart_busy,
    input  tx_overflow
  );

endinterface

// File: rtl/pito_sync_fifo.sv
// Single-clock circular-buffer FIFO.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (flushes the FIFO)
//   push/wdata - enqueue wdata; ignored while full (even if popping)
//   pop        - dequeue the head; ignored while empty
//   rdata      - current head entry (valid when !empty)
//   full/empty - occupancy flags
//   count      - number of stored entries
//
// DEPTH must be a power of two so the pointers wrap naturally.
module pito_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO refuses the push outright, so a simultaneous pop never
  // makes room within the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pito_dmem_router.sv
// Routes the core's data-memory port to the shared SRAM or to MMIO, and
// owns the UART transmit path (TX FIFO plus a pacing drain FSM).
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - pito_dmem_router_if slave modport carrying the core,
//                SRAM and UART signals plus the sticky tx_overflow flag
//
// Address map: addr[MSB]==0 is SRAM, otherwise MMIO at offset addr[7:0]
//   0x00 TXDATA (write pushes wdata[7:0] when be[0]), 0x04 STATUS (read-only),
//   anything else reads 0 and a write there raises tx_overflow.
module pito_dmem_router
  import pito_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pito_dmem_router_if.slave     bus
);

  localparam int MSB   = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(TX_FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_GUARD = GUARD;

  logic [7:0]            mmio_offset;
  logic                  is_mmio;
  logic                  is_txdata;
  logic                  is_status;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  gnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [7:0]            fifo_head;
  logic                  uart_wr;
  logic [7:0]            uart_data;

  logic [1:0]            state_q, state_d;
  logic                  rvalid_q, rvalid_d;
  logic                  sel_mem_q, sel_mem_d;
  logic [DATA_WIDTH-1:0] mmio_rdata_q, mmio_rdata_d;
  logic                  tx_overflow_q, tx_overflow_d;

  // Target decode and grant. The only reason to withhold a grant is a
  // TXDATA push while the FIFO is full; the core then holds its request.
  always_comb begin
    mmio_offset = bus.core_addr[7:0];
    is_mmio     = bus.core_addr[MSB];
    is_txdata   = is_mmio && (mmio_offset == PITO_MMIO_TXDATA);
    is_status   = is_mmio && (mmio_offset == PITO_MMIO_STATUS);
    push_req    = bus.core_req && bus.core_we && is_txdata && bus.core_be[0];
    gnt         = bus.core_req && !(push_req && fifo_full);
    push        = push_req && !fifo_full;
  end

  assign bus.core_gnt  = gnt;
  assign bus.mem_req   = bus.core_req && !is_mmio;
  assign bus.mem_we    = bus.core_we;
  assign bus.mem_addr  = bus.core_addr;
  assign bus.mem_wdata = bus.core_wdata;
  assign bus.mem_be    = bus.core_be;

  pito_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.core_wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Response path: remember whether the next-cycle data comes from the SRAM
  // (granted SRAM reads only) or from the captured MMIO word. Writes of any
  // kind capture zero so they respond with rdata=0.
  always_comb begin
    rvalid_d     = gnt;
    sel_mem_d    = gnt && !is_mmio && !bus.core_we;
    mmio_rdata_d = '0;
    if (gnt && is_status && !bus.core_we) begin
      mmio_rdata_d[0]    = fifo_empty;
      mmio_rdata_d[1]    = fifo_full;
      mmio_rdata_d[15:8] = 8'(fifo_count);
    end
    tx_overflow_d = tx_overflow_q;
    if (gnt && bus.core_we && is_mmio && !is_txdata && !is_status) begin
      tx_overflow_d = 1'b1;
    end
  end

  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = !rvalid_q ? '0 :
                           (sel_mem_q ? bus.mem_rdata : mmio_rdata_q);
  assign bus.tx_overflow = tx_overflow_q;

  // Drain FSM: one byte per IDLE->SEND->GUARD loop. GUARD gives the UART a
  // cycle to raise busy before IDLE looks at it again.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    uart_wr   = 1'b0;
    uart_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !bus.uart_busy) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        pop       = 1'b1;
        uart_wr   = 1'b1;
        uart_data = fifo_head;
        state_d   = ST_GUARD;
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.uart_wr   = uart_wr;
  assign bus.uart_data = uart_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rvalid_q      <= 1'b0;
      sel_mem_q     <= 1'b0;
      mmio_rdata_q  <= '0;
      tx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rvalid_q      <= rvalid_d;
      sel_mem_q     <= sel_mem_d;
      mmio_rdata_q  <= mmio_rdata_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

endmodule
